read_port_arbiter: RTL

READ_PORT_ARBITER -- requirements
Module: read_port_arbiter

---
 rtl/read_port_arbiter_if.sv | 26 ++
 rtl/read_port_arbiter.sv | 84 ++++++++
 2 files changed

// File: rtl/read_port_arbiter_if.sv
// Shared read-port bundle: per-requester requests and addresses in, grant,
// completion strobe and captured read data out, plus the register-file mux tap.
interface read_port_arbiter_if #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 4
);
    logic [NREQ-1:0] req;
    logic [AW-1:0]   ra0, ra1, ra2, ra3;
    logic [AW-1:0]   ra;
    logic [DW-1:0]   rdout;
    logic [NREQ-1:0] gnt;
    logic [NREQ-1:0] ack;
    logic [DW-1:0]   rdata;
    logic            busy;

    modport master (
        output req, ra0, ra1, ra2, ra3, rdout,
        input  ra, gnt, ack, rdata, busy
    );

    modport slave (
        input  req, ra0, ra1, ra2, ra3, rdout,
        output ra, gnt, ack, rdata, busy
    );
endinterface

// File: rtl/read_port_arbiter.sv
// Round-robin arbiter sharing one register-file read port among NREQ requesters;
// each read runs IDLE -> SEL -> DONE, so one read completes every three cycles.
module read_port_arbiter #(
    parameter int NREQ = 4,
    parameter int AW   = 3,
    parameter int DW   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    read_port_arbiter_if.slave   bus
);
    localparam int IW = $clog2(NREQ);

    typedef enum logic [1:0] {IDLE, SEL, DONE} state_t;

    state_t          state, nxt;
    logic [IW-1:0]   ptr, idx, cand, win_idx;
    logic            win_vld;
    logic [AW-1:0]   ra_q;
    logic [DW-1:0]   rdata_q;
    logic [AW-1:0]   ra_in [NREQ];

    assign ra_in[0] = bus.ra0;
    assign ra_in[1] = bus.ra1;
    assign ra_in[2] = bus.ra2;
    assign ra_in[3] = bus.ra3;

    // Scan from the highest offset down so the lowest offset from ptr wins;
    // index arithmetic wraps naturally because NREQ is a power of two.
    always_comb begin
        win_vld = 1'b0;
        win_idx = '0;
        cand    = '0;
        for (int off = NREQ-1; off >= 0; off--) begin
            cand = ptr + IW'(off);
            if (bus.req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (win_vld) nxt = SEL;
            SEL:     nxt = DONE;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // Address is captured on the IDLE sampling edge, so later RAi changes
    // and request drops cannot disturb the transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            idx     <= '0;
            ra_q    <= '0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: if (win_vld) begin
                    idx  <= win_idx;
                    ra_q <= ra_in[win_idx];
                end
                SEL:  rdata_q <= bus.rdout;
                DONE: ptr     <= idx + IW'(1);
                default: ;
            endcase
        end
    end

    assign bus.ra    = ra_q;
    assign bus.rdata = rdata_q;
    assign bus.busy  = (state != IDLE);
    assign bus.gnt   = (state != IDLE) ? (NREQ'(1) << idx) : '0;
    assign bus.ack   = (state == DONE) ? (NREQ'(1) << idx) : '0;
endmodule
